// File: rtl/riscv_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, a single-entry
// output buffer toward decode, and redirect handling that kills stale responses.
module riscv_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_i,
    input  logic [31:0] br_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_cnt_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        OUT   = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'd3;

    state_e      state_q;
    logic        kill_q;
    logic [31:0] pc_q;
    logic [31:0] inflight_pc_q;
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic [31:0] inst_cnt_q;
    logic [31:0] pc_d;

    // A redirect always wins over the sequential +4 advance.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (br_i) begin
            pc_d = br_pc_i & ~32'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= FETCH;
            kill_q        <= 1'b0;
            pc_q          <= RESET_PC_AL;
            inflight_pc_q <= 32'd0;
            inst_valid_q  <= 1'b0;
            inst_q        <= 32'd0;
            inst_pc_q     <= 32'd0;
            inst_cnt_q    <= 32'd0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_gnt_i) begin
                        inflight_pc_q <= pc_q;
                        pc_q          <= pc_d;
                        kill_q        <= br_i;
                        state_q       <= WAIT;
                    end else if (br_i) begin
                        pc_q <= pc_d;
                    end
                end
                WAIT: begin
                    if (br_i) begin
                        pc_q <= pc_d;
                    end
                    // A response that lands with a redirect, or after one, is stale.
                    if (imem_rvalid_i) begin
                        kill_q <= 1'b0;
                        if (kill_q || br_i) begin
                            state_q <= FETCH;
                        end else begin
                            inst_q       <= imem_rdata_i;
                            inst_pc_q    <= inflight_pc_q;
                            inst_valid_q <= 1'b1;
                            state_q      <= OUT;
                        end
                    end else if (br_i) begin
                        kill_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (!stall_i) begin
                        inst_cnt_q <= inst_cnt_q + 32'd1;
                    end
                    if (br_i || !stall_i) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= FETCH;
                    end
                    if (br_i) begin
                        pc_q <= pc_d;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign imem_req_o   = rst && (state_q == FETCH);
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_cnt_o   = inst_cnt_q;

endmodule

// File: doc/riscv_fetch_ctrl.md
RISCV_FETCH_CTRL -- requirements
Module: riscv_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on the rising edge only.
REQ-003 Port rst, input, 1: reset, synchronous and active-low.
REQ-004 Port br_i, input, 1: redirect request from execute.
REQ-005 Port br_pc_i, input, 32: redirect target; bits [1:0] SHALL be ignored and treated as 0.
REQ-006 Port stall_i, input, 1: decode cannot accept the presented instruction.
REQ-007 Port imem_req_o, output, 1: instruction memory request.
REQ-008 Port imem_addr_o, output, 32: request address, equal to pc_o.
REQ-009 Port imem_gnt_i, input, 1: memory accepts the request this cycle.
REQ-010 Port imem_rvalid_i, input, 1: read data valid.
REQ-011 Port imem_rdata_i, input, 32: read data.
REQ-012 Port pc_o, output, 32: next fetch address (fetch PC register).
REQ-013 Port inst_valid_o, output, 1: the instruction on inst_o is valid.
REQ-014 Port inst_o, output, 32: fetched instruction.
REQ-015 Port inst_pc_o, output, 32: address of inst_o.
REQ-016 Port inst_cnt_o, output, 32: count of instructions consumed.

Function
REQ-017 The block SHALL use FSM states FETCH, WAIT and OUT, plus a 1-bit kill flag and a registered inflight_pc.
REQ-018 FETCH behaviour SHALL be:
- imem_req_o=1.
- On imem_gnt_i: inflight_pc<=pc_o, pc_o<=pc_o+4 (mod 2^32, wrapping 0xFFFF_FFFC->0), then go to WAIT.
REQ-019 imem_req_o SHALL be 0 in WAIT and OUT; at most one request SHALL be outstanding.
REQ-020 WAIT behaviour on imem_rvalid_i with kill=0: inst_o<=imem_rdata_i, inst_pc_o<=inflight_pc, inst_valid_o<=1, go to OUT.
- inst_valid_o SHALL rise exactly one cycle after rvalid.
REQ-021 WAIT behaviour on imem_rvalid_i with kill=1: discard the data, clear kill, go to FETCH; inst_valid_o SHALL stay 0.
REQ-022 In OUT, inst_valid_o=1 and stall_i=0 SHALL constitute consumption:
- inst_valid_o<=0 and inst_cnt_o<=inst_cnt_o+1 (wrapping).
- Go to FETCH.
REQ-023 In OUT with stall_i=1, inst_o, inst_pc_o and inst_valid_o SHALL hold unchanged.
REQ-024 br_i=1 in any state SHALL load pc_o<=br_pc_i&~3, overriding the +4 of REQ-018, with the following per-state effects:
- FETCH without gnt: next request SHALL use the new address.
- FETCH with gnt in the same cycle: go to WAIT with kill<=1.
- WAIT without rvalid: kill<=1.
- WAIT with rvalid in the same cycle: discard the data, go to FETCH.
- OUT: inst_valid_o<=0, go to FETCH; inst_cnt_o SHALL increment only if stall_i=0 that cycle.
REQ-025 br_i SHALL take priority over stall_i.
REQ-026 imem_rvalid_i SHALL be ignored in FETCH and OUT.
REQ-027 inst_o and inst_pc_o SHALL change only on a REQ-020 capture.

Reset
REQ-028 When rst=0 at a rising edge, the block SHALL set:
- state=FETCH, pc_o=RESET_PC, kill=0, inst_valid_o=0.
- inst_o=0, inst_pc_o=0, inst_cnt_o=0.
REQ-029 Reset SHALL override all other inputs, including mid-WAIT; a response arriving after reset release while in FETCH SHALL be ignored.
REQ-030 imem_req_o SHALL be 0 while rst=0 and SHALL be 1 in the first cycle after release.

Verification
REQ-031 Reset, then gnt immediately and rvalid two cycles later with rdata=0x00000013, stall_i=0 -> inst_valid_o high for one cycle with inst_o=0x13 and inst_pc_o=0; pc_o=4; inst_cnt_o=1; next request at address 4.
REQ-032 Hold stall_i=1 for 3 cycles while in OUT -> inst_o and inst_pc_o stable for 3 cycles; no request issued; inst_cnt_o unchanged until stall_i drops.
REQ-033 br_i=1 with br_pc_i=0x103 during WAIT -> the pending response is discarded with inst_valid_o=0; the next request goes to address 0x100.
REQ-034 br_i and imem_gnt_i both high in FETCH with br_pc_i=0x200 -> the granted response is dropped; the following request goes to 0x200.
REQ-035 Preload pc_o to 0xFFFFFFFC via redirect, then fetch -> pc_o wraps to 0; inst_pc_o=0xFFFFFFFC.
REQ-036 rst=0 asserted in WAIT, then rvalid after release -> outputs at reset values; the response is ignored; the first request goes to RESET_PC.
